// File: rtl/social_pkg.sv
// Shared encodings and defaults for the social-battery block and the upstream mood FSM.
package social_pkg;

   typedef enum logic [1:0] {
      MoodHappy     = 2'b00,
      MoodAwkward   = 2'b01,
      MoodVeryHappy = 2'b10,
      MoodInvalid   = 2'b11
   } mood_e;

   typedef enum logic [1:0] {
      StNormal   = 2'b00,
      StLow      = 2'b01,
      StBreakReq = 2'b10,
      StRecharge = 2'b11
   } state_e;

   localparam int unsigned LevelW         = 4;
   localparam int unsigned DefMaxLevel    = 15;
   localparam int unsigned DefLowThresh   = 4;
   localparam int unsigned DefResumeLevel = 12;
   localparam int unsigned DefDrainDiv    = 2;

endpackage

// File: rtl/social_drain_tick.sv
// Drain prescaler: emits one tick every DRAIN_DIV enabled cycles, clears whenever disabled.
module social_drain_tick
   import social_pkg::*;
#(
   parameter int unsigned DRAIN_DIV = DefDrainDiv
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CntW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
   localparam logic [CntW-1:0] Last = CntW'(DRAIN_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = enable && (cnt_q == Last);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (!enable || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/social_battery.sv
// Social-battery level tracker: drains while awkward, charges while very happy or recharging,
// and requests a break once the battery is flat.
module social_battery
   import social_pkg::*;
#(
   parameter int unsigned MAX_LEVEL    = DefMaxLevel,
   parameter int unsigned LOW_THRESH   = DefLowThresh,
   parameter int unsigned RESUME_LEVEL = DefResumeLevel,
   parameter int unsigned DRAIN_DIV    = DefDrainDiv
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          mood,
   input  logic                break_ack,
   output logic [LevelW-1:0]   level,
   output logic                low_warn,
   output logic                break_req,
   output logic                mood_err
);

   localparam logic [LevelW-1:0] MaxLvl    = LevelW'(MAX_LEVEL);
   localparam logic [LevelW-1:0] LowLvl    = LevelW'(LOW_THRESH);
   localparam logic [LevelW-1:0] ResumeLvl = LevelW'(RESUME_LEVEL);

   state_e            state_q, state_d;
   logic [LevelW-1:0] level_q, level_d;
   logic              mood_err_q;
   logic              drain_en;
   logic              tick;
   mood_e             mood_v;

   assign mood_v = mood_e'(mood);
   // Prescaler is held clear during recharge so drain restarts from a full period afterwards.
   assign drain_en = (mood_v == MoodAwkward) && (state_q != StRecharge);

   social_drain_tick #(
      .DRAIN_DIV (DRAIN_DIV)
   ) u_drain_tick (
      .clk    (clk),
      .reset  (reset),
      .enable (drain_en),
      .tick   (tick)
   );

   always_comb begin
      level_d = level_q;
      if (state_q == StRecharge) begin
         if (level_q != MaxLvl) level_d = level_q + 1'b1;
      end else begin
         case (mood_v)
            MoodAwkward: begin
               if (tick && (level_q != '0)) level_d = level_q - 1'b1;
            end
            MoodVeryHappy: begin
               if (level_q != MaxLvl) level_d = level_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StNormal:   if (level_q <= LowLvl) state_d = StLow;
         StLow: begin
            if (level_q == '0)         state_d = StBreakReq;
            else if (level_q > LowLvl) state_d = StNormal;
         end
         StBreakReq: if (break_ack) state_d = StRecharge;
         StRecharge: if (level_q >= ResumeLvl) state_d = StNormal;
         default:    state_d = StNormal;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StNormal;
         level_q    <= MaxLvl;
         mood_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         mood_err_q <= mood_err_q | (mood_v == MoodInvalid);
      end
   end

   assign level     = level_q;
   assign low_warn  = (state_q == StLow);
   assign break_req = (state_q == StBreakReq);
   assign mood_err  = mood_err_q;

endmodule
